// File: rtl/stream_fifo_burst_arbiter.sv
// Burst round-robin arbiter feeding one FIFO write port from two streams.
// Ports: ap_clk/ap_rst_n, in0_V_*/in1_V_* sources, fifo_count, out_V_* sink, grant, busy.
module stream_fifo_burst_arbiter #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 1152,
    parameter int CNT_W = 11,
    parameter int BURST = 9
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [WIDTH-1:0] in0_V_TDATA,
    input  logic             in0_V_TVALID,
    output logic             in0_V_TREADY,
    input  logic [WIDTH-1:0] in1_V_TDATA,
    input  logic             in1_V_TVALID,
    output logic             in1_V_TREADY,
    input  logic [CNT_W-1:0] fifo_count,
    output logic [WIDTH-1:0] out_V_TDATA,
    output logic             out_V_TVALID,
    input  logic             out_V_TREADY,
    output logic [1:0]       grant,
    output logic             busy
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   beat_cnt, beat_nx;
    logic            last, last_nx;
    logic            sel, sel_nx;

    logic [CNT_W:0]  need;
    logic            room;
    logic            elig0, elig1;
    logic            xfer, done;

    // One extra bit keeps count + BURST from wrapping.
    assign need  = {1'b0, fifo_count} + (CNT_W+1)'(BURST);
    assign room  = (need <= (CNT_W+1)'(DEPTH));
    assign elig0 = in0_V_TVALID & room;
    assign elig1 = in1_V_TVALID & room;
    assign xfer  = out_V_TVALID & out_V_TREADY;
    assign done  = xfer && (beat_cnt == BW'(BURST-1));

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            last     <= 1'b1;
            sel      <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_nx;
            last     <= last_nx;
            sel      <= sel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        beat_nx  = beat_cnt;
        last_nx  = last;
        sel_nx   = sel;
        unique case (state)
            S_IDLE: begin
                if (elig0 | elig1) begin
                    state_nx = S_BURST;
                    beat_nx  = '0;
                    // On a tie the requester that did not go last wins.
                    sel_nx   = (elig0 & elig1) ? ~last : elig1;
                end
            end
            S_BURST: begin
                if (done) begin
                    state_nx = S_IDLE;
                    beat_nx  = '0;
                    last_nx  = sel;
                end else if (xfer) begin
                    beat_nx = beat_cnt + BW'(1);
                end
            end
        endcase
    end

    always_comb begin
        out_V_TDATA  = in0_V_TDATA;
        out_V_TVALID = 1'b0;
        in0_V_TREADY = 1'b0;
        in1_V_TREADY = 1'b0;
        grant        = 2'b00;
        busy         = 1'b0;
        if (state == S_BURST) begin
            busy         = 1'b1;
            grant        = sel ? 2'b10 : 2'b01;
            out_V_TDATA  = sel ? in1_V_TDATA : in0_V_TDATA;
            out_V_TVALID = sel ? in1_V_TVALID : in0_V_TVALID;
            in0_V_TREADY = ~sel & out_V_TREADY;
            in1_V_TREADY = sel & out_V_TREADY;
        end
    end

endmodule

// File: tb/tb_stream_fifo_burst_arbiter.sv
// Directed bench for stream_fifo_burst_arbiter.
// Drives two counting producers and checks grants, data and handshakes.
module tb_stream_fifo_burst_arbiter;

    localparam int WIDTH = 72;
    localparam int CNT_W = 11;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic [WIDTH-1:0] in0_V_TDATA;
    logic             in0_V_TVALID;
    logic             in0_V_TREADY;
    logic [WIDTH-1:0] in1_V_TDATA;
    logic             in1_V_TVALID;
    logic             in1_V_TREADY;
    logic [CNT_W-1:0] fifo_count;
    logic [WIDTH-1:0] out_V_TDATA;
    logic             out_V_TVALID;
    logic             out_V_TREADY;
    logic [1:0]       grant;
    logic             busy;

    logic [63:0] ptr0 = 64'd0;
    logic [63:0] ptr1 = 64'd0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 ap_clk = ~ap_clk;

    // Producers advance to the next beat after every accepted transfer.
    assign in0_V_TDATA = {8'hA0, ptr0};
    assign in1_V_TDATA = {8'hB1, ptr1};

    always @(posedge ap_clk) begin
        if (in0_V_TVALID && in0_V_TREADY) ptr0 <= ptr0 + 64'd1;
        if (in1_V_TVALID && in1_V_TREADY) ptr1 <= ptr1 + 64'd1;
    end

    stream_fifo_burst_arbiter #(
        .WIDTH(72),
        .DEPTH(1152),
        .CNT_W(11),
        .BURST(9)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in0_V_TDATA (in0_V_TDATA),
        .in0_V_TVALID(in0_V_TVALID),
        .in0_V_TREADY(in0_V_TREADY),
        .in1_V_TDATA (in1_V_TDATA),
        .in1_V_TVALID(in1_V_TVALID),
        .in1_V_TREADY(in1_V_TREADY),
        .fifo_count  (fifo_count),
        .out_V_TDATA (out_V_TDATA),
        .out_V_TVALID(out_V_TVALID),
        .out_V_TREADY(out_V_TREADY),
        .grant       (grant),
        .busy        (busy)
    );

    task automatic check(input string tag,
                         input logic [71:0] got,
                         input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; checks idle outputs at the negedge.
    task automatic expect_idle(input string tag);
        @(negedge ap_clk);
        check({tag, "_grant"}, 72'(grant), 72'(2'b00));
        check({tag, "_busy"}, 72'(busy), 72'(0));
        check({tag, "_ovalid"}, 72'(out_V_TVALID), 72'(0));
        check({tag, "_rdy0"}, 72'(in0_V_TREADY), 72'(0));
        check({tag, "_rdy1"}, 72'(in1_V_TREADY), 72'(0));
        @(posedge ap_clk);
        #1;
    endtask

    // Expects n unstalled beats from requester who, first index first.
    task automatic expect_burst(input string tag, input int who,
                                input int first, input int n);
        logic [7:0]  tagb;
        logic [1:0]  g;
        tagb = (who == 0) ? 8'hA0 : 8'hB1;
        g    = (who == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < n; i++) begin
            @(negedge ap_clk);
            check({tag, "_grant"}, 72'(grant), 72'(g));
            check({tag, "_busy"}, 72'(busy), 72'(1));
            check({tag, "_ovalid"}, 72'(out_V_TVALID), 72'(1));
            check({tag, "_data"}, out_V_TDATA,
                  {tagb, 64'(first + i)});
            check({tag, "_rdy0"}, 72'(in0_V_TREADY),
                  72'(who == 0));
            check({tag, "_rdy1"}, 72'(in1_V_TREADY),
                  72'(who == 1));
            @(posedge ap_clk);
            #1;
        end
    endtask

    initial begin
        int beats;
        int cyc;

        // 1: reset held with both valids high
        ap_rst_n     = 1'b0;
        in0_V_TVALID = 1'b1;
        in1_V_TVALID = 1'b1;
        fifo_count   = '0;
        out_V_TREADY = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        check("rst_grant", 72'(grant), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_ovalid", 72'(out_V_TVALID), 72'(0));
        check("rst_rdy0", 72'(in0_V_TREADY), 72'(0));
        check("rst_rdy1", 72'(in1_V_TREADY), 72'(0));
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // 2: alternation with both requesting
        expect_idle("t2_idle0");
        expect_burst("t2_b0", 0, 0, 9);
        expect_idle("t2_idle1");
        expect_burst("t2_b1", 1, 0, 9);
        expect_idle("t2_idle2");
        expect_burst("t2_b2", 0, 9, 9);
        in0_V_TVALID = 1'b0;
        in1_V_TVALID = 1'b0;
        expect_idle("t2_idle3");

        // 3: space threshold
        fifo_count   = 11'd1144;
        in0_V_TVALID = 1'b1;
        repeat (3) expect_idle("t3_full");
        fifo_count = 11'd1143;
        expect_idle("t3_arb");

        // 4: stalled burst, ready toggling 1010...
        beats = 0;
        cyc   = 0;
        while (beats < 9 && cyc < 40) begin
            out_V_TREADY = (cyc % 2 == 0);
            @(negedge ap_clk);
            check("t4_grant", 72'(grant), 72'(2'b01));
            check("t4_ovalid", 72'(out_V_TVALID), 72'(1));
            check("t4_data", out_V_TDATA,
                  {8'hA0, 64'(18 + beats)});
            check("t4_rdy0", 72'(in0_V_TREADY),
                  72'(out_V_TREADY));
            check("t4_rdy1", 72'(in1_V_TREADY), 72'(0));
            if (out_V_TREADY) beats++;
            cyc++;
            @(posedge ap_clk);
            #1;
        end
        check("t4_beats", 72'(beats), 72'(9));
        check("t4_cycles", 72'(cyc), 72'(17));
        out_V_TREADY = 1'b1;
        in0_V_TVALID = 1'b0;
        fifo_count   = '0;
        expect_idle("t4_end");

        // 5: lone requester gets back-to-back bursts
        in1_V_TVALID = 1'b1;
        expect_idle("t5_idle0");
        expect_burst("t5_b0", 1, 9, 9);
        expect_idle("t5_idle1");
        expect_burst("t5_b1", 1, 18, 9);
        expect_idle("t5_idle2");

        // 6: reset after 4 beats of an in1 burst
        expect_burst("t6_part", 1, 27, 4);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        check("t6_grant", 72'(grant), 72'(0));
        check("t6_busy", 72'(busy), 72'(0));
        check("t6_ovalid", 72'(out_V_TVALID), 72'(0));
        check("t6_rdy0", 72'(in0_V_TREADY), 72'(0));
        check("t6_rdy1", 72'(in1_V_TREADY), 72'(0));
        @(posedge ap_clk);
        #1;
        ap_rst_n     = 1'b1;
        in0_V_TVALID = 1'b1;
        in1_V_TVALID = 1'b1;
        expect_idle("t6_idle");
        expect_burst("t6_win", 0, 27, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
